// File: rtl/skew_symbol_buffer.sv
// Skewed symbol buffer: lane k sees symbol k of a word k advancing cycles
// after lane 0, with valid/erase/sof riding along; out_stall freezes all.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   in_data         LANES*SYM_W received word
//   in_erase        per-symbol erasure flags (post ordering)
//   in_sof          word is first of a frame
//   in_valid        input word qualifier
//   in_ready        = !out_stall
//   out_stall       downstream hold
//   out_sym         lane k symbol at [k*SYM_W +: SYM_W]
//   out_erase       lane k erasure flag
//   out_sof         lane k frame-start flag
//   out_valid       lane k real symbol (0 = bubble)
//   busy            any stage holds a valid symbol
module skew_symbol_buffer #(
  parameter int LANES     = 8,
  parameter int SYM_W     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*SYM_W-1:0] in_data,
  input  logic [LANES-1:0]       in_erase,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_stall,
  output logic [LANES*SYM_W-1:0] out_sym,
  output logic [LANES-1:0]       out_erase,
  output logic [LANES-1:0]       out_sof,
  output logic [LANES-1:0]       out_valid,
  output logic                   busy
);

  // Stage entry layout: {sym, erase, sof, valid}
  localparam int EW = SYM_W + 3;

  logic             adv;
  logic [LANES-1:0] lane_busy;

  assign adv      = !out_stall;
  assign in_ready = adv;
  assign busy     = |lane_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [SYM_W-1:0] sym_in;
    logic [EW-1:0]    ent;
    // pipe_q[0..k-1] are the delay stages, pipe_q[k] the output register
    logic [EW-1:0]    pipe_q [0:k];
    logic [k:0]       vld;

    if (MSB_FIRST != 0) begin : g_msb
      assign sym_in =
        in_data[(LANES-1-k)*SYM_W +: SYM_W];
    end else begin : g_lsb
      assign sym_in = in_data[k*SYM_W +: SYM_W];
    end

    // A missing word enters as an all-zero bubble
    assign ent = in_valid
      ? {sym_in, in_erase[k], in_sof, 1'b1}
      : '0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= k; j++) begin
          pipe_q[j] <= '0;
        end
      end else if (adv) begin
        pipe_q[0] <= ent;
        for (int j = 1; j <= k; j++) begin
          pipe_q[j] <= pipe_q[j-1];
        end
      end
    end

    for (genvar j = 0; j <= k; j++) begin : g_vld
      assign vld[j] = pipe_q[j][0];
    end

    assign lane_busy[k] = |vld;

    assign out_sym[k*SYM_W +: SYM_W] =
      pipe_q[k][EW-1 -: SYM_W];
    assign out_erase[k] = pipe_q[k][2];
    assign out_sof[k]   = pipe_q[k][1];
    assign out_valid[k] = pipe_q[k][0];
  end

endmodule

// File: tb/tb_skew_symbol_buffer.sv
// Bench for skew_symbol_buffer: history-based model of accepted words
// indexed by advancing edge; lane k shows the entry from k edges back.
module tb_skew_symbol_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  in_erase = '0;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_stall = 1'b0;
  logic [15:0] out_sym;
  logic [7:0]  out_erase;
  logic [7:0]  out_sof;
  logic [7:0]  out_valid;
  logic        busy;

  logic [11:0] in_data_b = '0;
  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [11:0] out_sym_b;
  logic [3:0]  out_erase_b;
  logic [3:0]  out_sof_b;
  logic [3:0]  out_valid_b;
  logic        busy_b;

  skew_symbol_buffer #(
    .LANES(8), .SYM_W(2), .MSB_FIRST(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_erase(in_erase),
    .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .out_stall(out_stall),
    .out_sym(out_sym), .out_erase(out_erase),
    .out_sof(out_sof), .out_valid(out_valid),
    .busy(busy)
  );

  skew_symbol_buffer #(
    .LANES(4), .SYM_W(3), .MSB_FIRST(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_erase(4'b0),
    .in_sof(1'b0), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .out_stall(1'b0),
    .out_sym(out_sym_b), .out_erase(out_erase_b),
    .out_sof(out_sof_b), .out_valid(out_valid_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one entry per advancing edge since time 0
  logic        ev [4096];
  logic [15:0] ed [4096];
  logic [7:0]  ee [4096];
  logic        es [4096];
  int          n    = 0;
  int          base = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_out(
    output logic [15:0] sym,
    output logic [7:0]  er,
    output logic [7:0]  sf,
    output logic [7:0]  vl,
    output logic        bz
  );
    sym = '0; er = '0; sf = '0; vl = '0; bz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = n - 1 - k;
      if (idx >= base) begin
        vl[k] = ev[idx];
        sym[k*2 +: 2] = ed[idx][k*2 +: 2];
        er[k] = ee[idx][k];
        sf[k] = es[idx];
        if (ev[idx]) bz = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [15:0] s;
    logic [7:0]  e, f, v;
    logic        b;
    model_out(s, e, f, v, b);
    chk("out_sym", out_sym, s);
    chk("out_erase", out_erase, e);
    chk("out_sof", out_sof, f);
    chk("out_valid", out_valid, v);
    chk("busy", busy, b);
  endtask

  task automatic step(input logic v,
                      input logic [15:0] d,
                      input logic [7:0] e,
                      input logic s,
                      input logic st);
    in_valid  = v;
    in_data   = d;
    in_erase  = e;
    in_sof    = s;
    out_stall = st;
    #1;
    chk("in_ready", in_ready, !st);
    @(posedge clk);
    if (rst && !st) begin
      ev[n] = v;
      ed[n] = v ? d : 16'h0;
      ee[n] = v ? e : 8'h0;
      es[n] = v & s;
      n++;
    end
    #1;
    compare_all();
  endtask

  task automatic bubbles(input int cnt);
    for (int i = 0; i < cnt; i++) step(0, 0, 0, 0, 0);
  endtask

  int exp6 [4] = '{7, 3, 1, 0};

  initial begin
    // Reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid_b", out_valid_b, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    bubbles(2);

    // Single word E4E4
    step(1, 16'hE4E4, 0, 0, 0);
    bubbles(9);

    // Continuous W0..W15, sof on W0
    for (int w = 0; w < 16; w++) begin
      logic [1:0] m;
      m = 2'(w % 4);
      step(1, {8{m}}, 0, (w == 0), 0);
    end
    bubbles(9);

    // Stall mid-stream with in_valid held
    for (int w = 0; w < 12; w++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (w == 5) begin
        for (int i = 0; i < 3; i++) step(1, d, 0, 0, 1);
      end
      step(1, d, 0, 0, 0);
    end
    bubbles(9);

    // Erasure with gaps of two bubbles
    for (int w = 0; w < 4; w++) begin
      step(1, 16'($urandom),
           (w == 1) ? 8'b0000_0100 : 8'h0, 0, 0);
      bubbles(2);
    end
    bubbles(8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           16'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0);
    end

    // Async reset mid-stream
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sym", out_sym, 0);
    chk("mid_rst_sof", out_sof, 0);
    chk("mid_rst_erase", out_erase, 0);
    chk("mid_rst_busy", busy, 0);
    base = n;
    @(posedge clk);
    #3 rst = 1'b1;
    bubbles(3);
    for (int i = 0; i < 100; i++) begin
      step($urandom_range(0, 1) != 0,
           16'($urandom), 8'($urandom),
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0);
    end
    bubbles(9);

    // MSB-first, 3-bit, 4-lane instance
    in_valid_b = 1'b1;
    in_data_b  = 12'o7310;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      in_valid_b = 1'b0;
      in_data_b  = '0;
      chk("b_valid", out_valid_b, 4'b1 << k);
      chk("b_sym", out_sym_b[k*3 +: 3], exp6[k]);
      chk("b_busy", busy_b, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("b_valid_end", out_valid_b, 0);
    chk("b_busy_end", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
